// File: rtl/dcache_uncached_wbuf_pkg.sv
// Shared memory-interface types for the uncached-store write buffer:
// buffered entry layout, drain FSM states and fixed AXI encodings.
package dcache_uncached_wbuf_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } uwb_entry_t;

    typedef enum logic [1:0] {
        UWB_IDLE,
        UWB_SEND,
        UWB_RESP
    } uwb_state_e;

endpackage

// File: rtl/dcache_uncached_wbuf_if.sv
// AXI write-only channel bundle (AW, W, B) between the write buffer (master)
// and the crossbar (slave).
interface dcache_uncached_wbuf_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [3:0]  wid;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;

    modport master (
        output awvalid, awaddr, awsize, awlen, awburst, awid,
        output wvalid, wdata, wstrb, wlast, wid,
        output bready,
        input  awready, wready, bvalid, bid
    );

    modport slave (
        input  awvalid, awaddr, awsize, awlen, awburst, awid,
        input  wvalid, wdata, wstrb, wlast, wid,
        input  bready,
        output awready, wready, bvalid, bid
    );

endinterface

// File: rtl/dcache_uncached_wbuf_fifo.sv
// Circular store FIFO for the uncached write buffer, with a parallel
// word-address compare across every occupied slot.
module uwb_fifo
    import dcache_uncached_wbuf_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  uwb_entry_t        push_entry,
    input  logic              pop,
    input  logic [31:2]       query_word,
    output uwb_entry_t        head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [DEPTH-1:0]  hit_vec
);

    localparam int PTR_W = $clog2(DEPTH);

    uwb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; occupancy is tracked by count, so stale
    // slots are never observed and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic [PTR_W-1:0] offset;
        assign offset     = PTR_W'(i) - rd_ptr;
        assign hit_vec[i] = (CNT_W'(offset) < count) &&
                            (mem[i].addr[31:2] == query_word);
    end

endmodule

// File: rtl/dcache_uncached_wbuf.sv
// Uncached-store write buffer: posts stores into a FIFO and drains them in
// order as single-beat AXI writes; reports word-address hazards to loads.
module dcache_uncached_wbuf
    import dcache_uncached_wbuf_pkg::*;
#(
    parameter int         DEPTH  = 16,
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [31:0] push_addr,
    input  logic [1:0]  push_size,
    input  logic [31:0] push_wdata,
    input  logic [3:0]  push_wstrb,
    input  logic [31:0] query_addr,
    output logic        query_hit,
    output logic        empty,
    dcache_uncached_wbuf_if.master axi
);

    uwb_state_e        state, state_next;
    logic              aw_done, aw_done_next;
    logic              w_done, w_done_next;
    logic              awvalid_int, wvalid_int, bready_int;
    logic              push_fire, pop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  hit_vec;
    uwb_entry_t        head, push_entry;
    logic              unused_bits;

    assign push_ready = !fifo_full;
    assign push_fire  = push_valid && push_ready;
    assign push_entry = '{addr: push_addr, size: push_size,
                          wdata: push_wdata, wstrb: push_wstrb};

    uwb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_fire),
        .push_entry (push_entry),
        .pop        (pop),
        .query_word (query_addr[31:2]),
        .head       (head),
        .count      (count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .hit_vec    (hit_vec)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= UWB_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path through
    // the case statement leaves a variable unassigned (no latch inference).
    always_comb begin
        state_next   = state;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        awvalid_int  = 1'b0;
        wvalid_int   = 1'b0;
        bready_int   = 1'b0;
        pop          = 1'b0;
        case (state)
            UWB_IDLE: begin
                if (!fifo_empty) begin
                    state_next   = UWB_SEND;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            UWB_SEND: begin
                // AW and W are independent; each drops once its own beat is taken.
                awvalid_int  = !aw_done;
                wvalid_int   = !w_done;
                aw_done_next = aw_done || (awvalid_int && axi.awready);
                w_done_next  = w_done  || (wvalid_int  && axi.wready);
                if (aw_done_next && w_done_next) state_next = UWB_RESP;
            end
            UWB_RESP: begin
                bready_int = 1'b1;
                if (axi.bvalid) begin
                    pop          = 1'b1;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = (count != CNT_W'(1) || push_fire) ? UWB_SEND : UWB_IDLE;
                end
            end
            default: state_next = UWB_IDLE;
        endcase
    end

    assign axi.awvalid = awvalid_int;
    assign axi.awaddr  = head.addr;
    assign axi.awsize  = {1'b0, head.size};
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awid    = AXI_ID;
    assign axi.wvalid  = wvalid_int;
    assign axi.wdata   = head.wdata;
    assign axi.wstrb   = head.wstrb;
    assign axi.wlast   = wvalid_int;
    assign axi.wid     = AXI_ID;
    assign axi.bready  = bready_int;

    assign query_hit = |hit_vec;
    assign empty     = fifo_empty && (state == UWB_IDLE);

    // Responses return in order and byte offsets don't affect hazards.
    assign unused_bits = ^{query_addr[1:0], axi.bid};

endmodule

// File: doc/dcache_uncached_wbuf.md
Name: dcache_uncached_wbuf

Overview:
- Uncached-store write buffer directly downstream of the data-cache request pipeline, between the cache miss/uncached path and the AXI crossbar write channel.
- Accepts uncached stores as posted writes so the CPU pipeline retires them without waiting for AXI B.
- Drains entries in order as single-beat AXI writes.
- Provides an address-hazard query so uncached loads can stall until any older overlapping store has drained.

Parameters:
- DEPTH, 16: number of buffered stores; power of two, at least 2.
- AXI_ID, 4'd1: constant AWID and WID value.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  store request from the cache.
- push_ready  out  1  buffer can accept; equals count != DEPTH.
- push_addr  in  32  byte address.
- push_size  in  2  AXI size (0=byte, 1=half, 2=word).
- push_wdata  in  32  store data, already lane-aligned.
- push_wstrb  in  4  byte strobes.
- query_addr  in  32  address of a pending uncached load.
- query_hit  out  1  a valid buffered or in-flight entry has addr[31:2] == query_addr[31:2].
- empty  out  1  count == 0 and FSM in IDLE.
- awvalid  out  1
- awready  in  1
- awaddr  out  32
- awsize  out  3  {1'b0, size}
- awlen  out  8  constant 0
- awburst  out  2  constant 2'b01
- awid  out  4  AXI_ID
- wvalid  out  1
- wready  in  1
- wdata  out  32
- wstrb  out  4
- wlast  out  1  equals wvalid
- wid  out  4  AXI_ID
- bvalid  in  1
- bready  out  1
- bid  in  4  ignored; responses return in order.

Behaviour:
- Storage is a circular FIFO of {addr, size, wdata, wstrb} with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap) and count (CNT_W bits).
- Push fires when push_valid && push_ready. The entry is written at wr_ptr, wr_ptr increments, and count increments at the clock edge.
- push_ready does not look ahead to a same-cycle pop. When full, push_ready stays 0 even in the cycle an entry retires.
- FSM states: IDLE, SEND, RESP.
  - IDLE: all AXI valids are 0 and bready is 0. If count != 0, go to SEND next cycle and clear the aw_done and w_done flags.
  - SEND: the head entry drives awaddr, awsize, wdata and wstrb. awvalid = !aw_done and wvalid = !w_done, issued concurrently.
    - aw_done sets on awvalid && awready; w_done sets on wvalid && wready. Both handshakes may occur in the same cycle.
    - When both are done (including same-cycle completion), go to RESP.
    - Payload is stable while any valid is high, per AXI.
  - RESP: bready = 1. On bvalid, pop the head (rd_ptr++, count--) in that cycle. Go to SEND if count-after-pop != 0, else IDLE.
- bresp is ignored; errors are not reported.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Latency: push accepted in cycle t gives SEND from cycle t+2 (awvalid and wvalid high) when the buffer was empty and idle. Best-case retire is at t+3 if awready, wready and bvalid are each 1 the first cycle sampled.
- query_hit is combinational over all entries between rd_ptr and wr_ptr, including the head in SEND/RESP.
  - It does not include a store being pushed in the same cycle.
  - The load path must hold the load while query_hit = 1.
- Reset values: count=0, ptrs=0, state=IDLE, aw_done=w_done=0. Derived outputs after reset: push_ready=1, empty=1, query_hit=0, awvalid=wvalid=bready=0.
  - Entry storage is not reset.
  - Reset mid-transaction abandons the in-flight AXI write; the interconnect is reset together with this block.

Decomposition:
- Add to the shared memory-interface package:
  - typedef uwb_entry_t {addr[31:0], size[1:0], wdata[31:0], wstrb[3:0]};
  - uwb state enum (IDLE, SEND, RESP);
  - constants AXI_BURST_INCR and AXI_LEN_SINGLE.
- One natural sub-module, uwb_fifo: storage, pointers, count, full/empty, and a parallel address-compare hit vector. The AXI FSM lives in the top module.

Test Plan:
- Single store: push addr=0x1FAF_0004, wdata=0xDEADBEEF, wstrb=4'hF, size=2; awready=wready=bvalid=1 → awvalid/wvalid high 2 cycles later with awaddr=0x1FAF0004, awsize=3'd2, wlast=1; empty returns to 1 one cycle after B.
- Fill to full: 16 pushes with awready=0 → push_ready=0 after the 16th. A 17th push_valid is not accepted. After awready=wready=bvalid=1, AXI writes drain in order 0..15, addresses checked sequentially.
- Channel skew: wready=1 for 3 cycles before awready → W handshakes exactly once, AW later, a single B retires one entry; no duplicate W beat.
- Concurrent push/pop: full-1 entries, push in the same cycle as bvalid in RESP → count unchanged, pointers wrap correctly across index 15→0.
- Hazard: buffer holds a store to 0x1FD0_F010 → query_addr=0x1FD0_F012 gives query_hit=1; 0x1FD0_F014 gives 0; after that entry's B, query_hit=0.
- Reset mid-SEND with awvalid=1 → next cycle awvalid=wvalid=bready=0, empty=1, push_ready=1.
